// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: word-address width and FSM state encoding.
package pc_sequencer_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned WordW = 32;

    typedef logic [AddrW-1:0] addr_t;
    typedef logic [WordW-1:0] word_t;

    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHalt
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, decode, redirect and halt signals between the sequencer and its environment.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;
    logic  instr_valid;
    word_t instr;
    addr_t instr_pc;
    logic  dec_ready;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  halt;
    logic  halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        input  imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        output imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/pc_sequencer_inc.sv
// Word-granular PC incrementer; wraps from all-ones to zero.
module pc_sequencer_inc
    import pc_sequencer_pkg::*;
(
    input  addr_t i_pc,
    output addr_t o_pc_next
);

    assign o_pc_next = i_pc + addr_t'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one-deep fetch buffer, redirect with in-flight
// discard, and a sticky halt that lets any outstanding request finish first.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_e r_state, w_state_nxt, w_resume;
    addr_t  r_pc, w_pc_nxt, w_pc_inc;
    addr_t  r_tgt, w_tgt_nxt;
    addr_t  r_instr_pc, w_instr_pc_nxt;
    word_t  r_instr, w_instr_nxt;
    logic   r_valid, w_valid_nxt;
    logic   r_discard, w_discard_nxt;
    logic   r_halt_pend, w_halt_pend_nxt;

    pc_sequencer_inc u_inc (
        .i_pc      (r_pc),
        .o_pc_next (w_pc_inc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_tgt_nxt       = r_tgt;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_valid_nxt     = r_valid;
        w_discard_nxt   = r_discard;
        w_halt_pend_nxt = r_halt_pend | bus.halt;
        // Every path that would re-enter FETCH lands in HALT once halt is pending.
        w_resume        = w_halt_pend_nxt ? StHalt : StFetch;

        unique case (r_state)
            StFetch: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        w_pc_nxt      = bus.redirect_pc;
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = w_resume;
                    end else if (r_discard) begin
                        w_pc_nxt      = r_tgt;
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = w_resume;
                    end else begin
                        w_instr_nxt    = bus.imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_valid_nxt    = 1'b1;
                        w_pc_nxt       = w_pc_inc;
                        w_state_nxt    = StDrain;
                    end
                end else if (bus.redirect_valid) begin
                    // Address must stay stable until ack; park the target instead.
                    w_discard_nxt = 1'b1;
                    w_tgt_nxt     = bus.redirect_pc;
                end
            end
            StDrain: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = w_resume;
                end else if (bus.dec_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = w_resume;
                end
            end
            StHalt: begin
                if (r_valid && bus.dec_ready) begin
                    w_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_tgt       <= '0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_valid     <= 1'b0;
            r_discard   <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_tgt       <= w_tgt_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_discard   <= w_discard_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    assign bus.imem_req    = (r_state == StFetch);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.halted      = (r_state == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model (fetch allowed only with an empty buffer and no halt).
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if bus_if ();

    pc_sequencer #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_buf[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_drop;
    bit          m_hp;
    bit          m_halted;

    logic        s_rst, s_ack, s_rdy, s_redir, s_halt;
    logic [31:0] s_rdata, s_rpc;

    task automatic model_update();
        bit consume;
        if (s_rst) begin
            m_pc     = RST_PC;
            m_tgt    = '0;
            m_drop   = 1'b0;
            m_hp     = 1'b0;
            m_halted = 1'b0;
            m_buf.delete();
            return;
        end
        consume = (m_buf.size() != 0) && s_rdy;
        m_hp    = m_hp | s_halt;
        if (m_halted) begin
            if (consume) void'(m_buf.pop_front());
        end else if (m_buf.size() == 0) begin
            if (s_ack) begin
                if (s_redir) begin
                    m_pc = s_rpc; m_drop = 1'b0; m_halted = m_hp;
                end else if (m_drop) begin
                    m_pc = m_tgt; m_drop = 1'b0; m_halted = m_hp;
                end else begin
                    m_buf.push_back('{ins: s_rdata, pc: m_pc});
                    m_pc = m_pc + 32'd1;
                end
            end else if (s_redir) begin
                m_drop = 1'b1;
                m_tgt  = s_rpc;
            end
        end else begin
            if (s_redir) begin
                m_buf.delete(); m_pc = s_rpc; m_halted = m_hp;
            end else if (consume) begin
                void'(m_buf.pop_front()); m_halted = m_hp;
            end
        end
    endtask

    function automatic logic [98:0] exp_vec();
        logic        req, v;
        logic [31:0] a, i, p;
        req = !m_halted && (m_buf.size() == 0);
        v   = (m_buf.size() != 0);
        a   = req ? m_pc : 32'h0;
        i   = v ? m_buf[0].ins : 32'h0;
        p   = v ? m_buf[0].pc : 32'h0;
        return {req, a, v, i, p, m_halted};
    endfunction

    function automatic logic [98:0] act_vec();
        logic [31:0] a, i, p;
        a = bus_if.imem_req ? bus_if.imem_addr : 32'h0;
        i = bus_if.instr_valid ? bus_if.instr : 32'h0;
        p = bus_if.instr_valid ? bus_if.instr_pc : 32'h0;
        return {bus_if.imem_req, a, bus_if.instr_valid, i, p, bus_if.halted};
    endfunction

    task automatic step();
        s_rst   = rst;
        s_ack   = bus_if.imem_ack;
        s_rdata = bus_if.imem_rdata;
        s_rdy   = bus_if.dec_ready;
        s_redir = bus_if.redirect_valid;
        s_rpc   = bus_if.redirect_pc;
        s_halt  = bus_if.halt;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.imem_ack       = 1'b0;
        bus_if.imem_rdata     = '0;
        bus_if.dec_ready      = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.halt           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.imem_ack       = 1'b1;
        bus_if.imem_rdata     = $urandom;
        bus_if.dec_ready      = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = $urandom;
        bus_if.halt           = 1'b1;
        step();
        idle_inputs();
        rst = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.halted}
            !== {1'b1, RST_PC, 1'b0, 1'b0})
            $display("FAIL reset_ctrl req=%b addr=%h valid=%b halted=%b want 1/%h/0/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.halted,
                     RST_PC);
        else n_pass++;
        n_checks++;
        if ({bus_if.instr, bus_if.instr_pc} !== 64'h0)
            $display("FAIL reset_buf instr=%h instr_pc=%h want 0/0",
                     bus_if.instr, bus_if.instr_pc);
        else n_pass++;
        // Reset while a discarded request is pending: the ack must be ignored.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_1234;
        step();
        bus_if.redirect_valid = 1'b0;
        rst = 1'b1;
        bus_if.imem_ack = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid} !== {1'b1, RST_PC, 1'b0})
            $display("FAIL reset_mid req=%b addr=%h valid=%b want 1/%h/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, RST_PC);
        else n_pass++;
        bus_if.imem_rdata = 32'hCAFE_0001;
        step();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.instr_valid, bus_if.instr_pc, bus_if.instr} !== {1'b1, RST_PC, 32'hCAFE_0001})
            $display("FAIL reset_first_fetch valid=%b pc=%h instr=%h want 1/%h/cafe0001",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int          n_instr;
        do_reset();
        bus_if.dec_ready = 1'b1;
        exp_pc  = RST_PC;
        n_instr = 0;
        for (int i = 0; i < 24; i++) begin
            bus_if.imem_ack   = bus_if.imem_req;
            bus_if.imem_rdata = $urandom;
            step();
            n_checks++;
            if (act_vec() !== exp_vec())
                $display("FAIL stream cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
            if (bus_if.instr_valid) begin
                n_checks++;
                if (bus_if.instr_pc !== exp_pc)
                    $display("FAIL stream_pc got=%h want=%h", bus_if.instr_pc, exp_pc);
                else n_pass++;
                exp_pc = exp_pc + 32'd1;
                n_instr++;
            end
        end
        n_checks++;
        if (n_instr !== 12)
            $display("FAIL stream_rate got=%0d instrs want=12", n_instr);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_wait_states();
        int n_acks;
        int wcnt;
        do_reset();
        bus_if.dec_ready = 1'b1;
        n_acks = 0;
        wcnt   = 0;
        for (int i = 0; i < 40; i++) begin
            bus_if.imem_ack   = bus_if.imem_req && (wcnt == 3);
            bus_if.imem_rdata = $urandom;
            if (bus_if.imem_req) begin
                n_checks++;
                if (bus_if.imem_addr !== RST_PC + n_acks)
                    $display("FAIL wait_addr cyc=%0d got=%h want=%h", i, bus_if.imem_addr,
                             RST_PC + n_acks);
                else n_pass++;
            end
            if (bus_if.imem_req && bus_if.imem_ack) begin
                wcnt = 0;
                n_acks++;
            end else if (bus_if.imem_req) begin
                wcnt++;
            end
            step();
            n_checks++;
            if (act_vec() !== exp_vec())
                $display("FAIL wait cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_redirect_discard();
        bit found;
        do_reset();
        bus_if.dec_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.imem_req && bus_if.imem_addr == 32'd5) begin
                found = 1'b1;
                break;
            end
            bus_if.imem_ack   = bus_if.imem_req;
            bus_if.imem_rdata = $urandom;
            step();
        end
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if (found !== 1'b1) $display("FAIL redir_reach_pc5 got=%b want=1", found);
        else n_pass++;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h40;
        step();
        bus_if.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid} !== {1'b1, 32'd5, 1'b0})
                $display("FAIL redir_hold cyc=%0d req=%b addr=%h valid=%b want 1/5/0", i,
                         bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid);
            else n_pass++;
            if (i == 1) begin
                bus_if.imem_ack   = 1'b1;
                bus_if.imem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid} !== {1'b1, 32'h40, 1'b0})
            $display("FAIL redir_target req=%b addr=%h valid=%b want 1/40/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        do_reset();
        d = $urandom;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = d;
        step();
        bus_if.imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus_if.imem_req, bus_if.instr_valid, bus_if.instr, bus_if.instr_pc}
                !== {1'b0, 1'b1, d, RST_PC})
                $display("FAIL bp_hold cyc=%0d req=%b valid=%b instr=%h pc=%h want 0/1/%h/%h",
                         i, bus_if.imem_req, bus_if.instr_valid, bus_if.instr,
                         bus_if.instr_pc, d, RST_PC);
            else n_pass++;
            step();
        end
        bus_if.dec_ready = 1'b1;
        step();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid}
            !== {1'b1, RST_PC + 32'd1, 1'b0})
            $display("FAIL bp_release req=%b addr=%h valid=%b want 1/%h/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, RST_PC + 32'd1);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_halt();
        logic [31:0] d;
        do_reset();
        step();
        bus_if.halt = 1'b1;
        step();
        bus_if.halt = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.halted} !== 2'b10)
            $display("FAIL halt_outstanding req=%b halted=%b want 1/0",
                     bus_if.imem_req, bus_if.halted);
        else n_pass++;
        d = $urandom;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = d;
        step();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.instr_valid, bus_if.instr, bus_if.halted}
            !== {1'b0, 1'b1, d, 1'b0})
            $display("FAIL halt_buffered req=%b valid=%b instr=%h halted=%b want 0/1/%h/0",
                     bus_if.imem_req, bus_if.instr_valid, bus_if.instr, bus_if.halted, d);
        else n_pass++;
        bus_if.dec_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus_if.imem_req, bus_if.instr_valid, bus_if.halted} !== 3'b001)
                $display("FAIL halt_state cyc=%0d req=%b valid=%b halted=%b want 0/0/1", i,
                         bus_if.imem_req, bus_if.instr_valid, bus_if.halted);
            else n_pass++;
            bus_if.redirect_valid = 1'b1;
            bus_if.redirect_pc    = $urandom;
            bus_if.dec_ready      = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.halted} !== {1'b1, RST_PC, 1'b0})
            $display("FAIL halt_exit req=%b addr=%h halted=%b want 1/%h/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.halted, RST_PC);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFF;
        bus_if.imem_ack       = 1'b1;
        step();
        bus_if.redirect_valid = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid} !== {1'b1, 32'hFFFF_FFFF, 1'b0})
            $display("FAIL wrap_preset req=%b addr=%h valid=%b want 1/ffffffff/0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid);
        else n_pass++;
        bus_if.imem_rdata = $urandom;
        step();
        bus_if.imem_ack  = 1'b0;
        bus_if.dec_ready = 1'b1;
        n_checks++;
        if ({bus_if.instr_valid, bus_if.instr_pc} !== {1'b1, 32'hFFFF_FFFF})
            $display("FAIL wrap_fetch valid=%b pc=%h want 1/ffffffff",
                     bus_if.instr_valid, bus_if.instr_pc);
        else n_pass++;
        step();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0000_0000})
            $display("FAIL wrap_next req=%b addr=%h want 1/00000000",
                     bus_if.imem_req, bus_if.imem_addr);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus_if.imem_ack       = bus_if.imem_req && ($urandom_range(0, 2) == 0);
            bus_if.imem_rdata     = $urandom;
            bus_if.dec_ready      = 1'($urandom_range(0, 1));
            bus_if.redirect_valid = ($urandom_range(0, 7) == 0);
            bus_if.redirect_pc    = $urandom;
            bus_if.halt           = ($urandom_range(0, 199) == 0);
            rst                   = ($urandom_range(0, 99) == 0);
            step();
            n_checks++;
            if (act_vec() !== exp_vec())
                $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_wait_states();
        test_redirect_discard();
        test_backpressure();
        test_halt();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
